led_chaser_ctrl: RTL
====================

# led_chaser_ctrl

Sequencing controller for the 8-bit LED chaser datapath. It selects one of four seed patterns, issues a one-cycle load of the seed into the chaser, and generates prescaled step strobes and a direction level. It also handles start/pause/resume, next-pattern and bounce requests from the board's (already debounced) push-button pulses. It sits between the button-conditioning logic and the chaser, which consumes `initstate`, `load`, `step` and `dir`.

## Interface
- `DIV_BASE`, default 4: clock cycles per step at `speed_sel`=0; must be ≥2.
- `BOUNCE_LEN`, default 7: steps per sweep before direction reverses in bounce mode; must be ≥1.
- `clock` input, 1: single system clock, all logic on the rising edge.
- `reset` input, 1: asynchronous, active-high; clears all state.
- `start` input, 1: single-cycle pulse; start from IDLE, or resume from PAUSE.
- `stop` input, 1: single-cycle pulse; pause stepping.
- `next_pat` input, 1: single-cycle pulse; advance pattern index and reload.
- `speed_sel` input, 2: step period = `DIV_BASE` << `speed_sel` cycles.
- `bounce` input, 1: level; 1 = reverse direction every `BOUNCE_LEN` steps.
- `initstate` output, 8: seed pattern presented to the chaser, held between loads.
- `load` output, 1: one-cycle strobe; chaser loads `initstate`.
- `step` output, 1: one-cycle strobe; chaser shifts/rotates once.
- `dir` output, 1: 0 = rotate left, 1 = rotate right.
- `busy` output, 1: high while in RUN.
- `pat_idx` output, 2: current pattern index.

## Operation
- Pattern table (index → seed): 0 → 8'b00000011, 1 → 8'b00000001, 2 → 8'b10000001, 3 → 8'b00001111.
- States: IDLE, LOAD, RUN, PAUSE.
- Request priority, same in every state: `stop` > `next_pat` > `start`. Requests not listed for a state are ignored.
- IDLE:
  - `start` → LOAD.
  - `next_pat` → increments `pat_idx` and stays in IDLE.
- LOAD, lasts exactly one cycle:
  - `load`=1, `initstate`=table[`pat_idx`].
  - Clears prescaler and sweep counter; sets `dir`=0.
  - Latches period from `speed_sel`.
  - Always → RUN. Requests arriving during LOAD are ignored.
- RUN:
  - Prescaler counts 0..P-1. At P-1: `step`=1 for one cycle, prescaler wraps to 0, period is re-latched from `speed_sel`.
  - `stop` → PAUSE. No `step` is issued in that cycle, even if the prescaler is at P-1. Prescaler holds its value.
  - `next_pat` → `pat_idx` = (`pat_idx`+1) mod 4 (3 wraps to 0), then → LOAD.
- PAUSE:
  - Prescaler and sweep counter hold.
  - `start` → RUN; counting continues from the held value.
  - `next_pat` → increment index, then → LOAD.
- Bounce:
  - Sweep counter increments on each `step` while `bounce`=1.
  - On the step where the counter reaches `BOUNCE_LEN`-1: counter clears and `dir` toggles (registered), so the following step uses the new direction.
  - `bounce`=0: counter held at 0, `dir` holds its current value.
- Arithmetic: prescaler width sized for `DIV_BASE`<<3. Sweep counter is ⌈log2(`BOUNCE_LEN`)⌉ bits, minimum 1.

## Timing
- All outputs are registered.
- Reset values: `initstate`=8'h00, `load`=0, `step`=0, `dir`=0, `busy`=0, `pat_idx`=0, state IDLE, both counters 0.
- Reset is asynchronous and may occur mid-operation. Assertion forces reset values immediately. After deassertion the block waits in IDLE for `start`.
- `start` sampled at edge k in IDLE → `load`=1 in cycle k+1 → `busy`=1 from cycle k+2.
- If `load` is high in cycle L, the first `step` is high in cycle L+P, then every P cycles. `speed_sel`=0 with `DIV_BASE`=4 gives P=4.
- `speed_sel` changes take effect at the next wrap; the current period always completes at its old length.
- `stop` at edge k → `busy`=0 and `step`=0 from cycle k+1.
- `next_pat` in RUN at edge k → `load` in cycle k+1 with the new seed.
- Simultaneous `stop`+`next_pat` in RUN → PAUSE, index unchanged.

## Test plan
- Reset, then `start`:
  - `load` pulses once with `initstate`=8'b00000011.
  - `step` pulses every 4 cycles at `speed_sel`=0; `dir`=0; `busy`=1.
- `speed_sel`=2 mid-run: current 4-cycle period completes, then steps every 16 cycles.
- Pattern wrap: from idx 3 in RUN, `next_pat` → `pat_idx`=0, `load` with 8'b00000011, first step 4 cycles after `load`.
- `bounce`=1, `BOUNCE_LEN`=7: `dir` 0 for steps 1–7, 1 for steps 8–14, 0 again from step 15.
- Pause/resume:
  - `stop` 2 cycles after a step → no steps during PAUSE.
  - `start` → next step 2 cycles after RUN is re-entered (held prescaler).
  - Simultaneous `stop`+`next_pat` → PAUSE, `pat_idx` unchanged.
- Async reset asserted mid-RUN, between clock edges: all outputs go to reset values immediately, before the next clock edge. `start` is ignored while reset is high.

Source files
------------

// File: rtl/led_chaser_ctrl_if.sv
// Request and strobe bundle between the button-conditioning logic (master)
// and the LED chaser sequencing controller (slave).
interface led_chaser_ctrl_if;
  logic       start;
  logic       stop;
  logic       next_pat;
  logic [1:0] speed_sel;
  logic       bounce;
  logic [7:0] initstate;
  logic       load;
  logic       step;
  logic       dir;
  logic       busy;
  logic [1:0] pat_idx;

  modport master (
    output start, stop, next_pat, speed_sel, bounce,
    input  initstate, load, step, dir, busy, pat_idx
  );

  modport slave (
    input  start, stop, next_pat, speed_sel, bounce,
    output initstate, load, step, dir, busy, pat_idx
  );
endinterface

// File: rtl/led_chaser_ctrl.sv
// Sequencing controller for the 8-bit LED chaser: seed selection, one-cycle
// load, prescaled step strobes and bounce-mode direction control.
module led_chaser_ctrl #(
  parameter int DIV_BASE   = 4,
  parameter int BOUNCE_LEN = 7
) (
  input  logic             clock,
  input  logic             reset,
  led_chaser_ctrl_if.slave bus
);

  localparam int PW = $clog2(DIV_BASE << 3);
  localparam int SW = (BOUNCE_LEN > 1) ? $clog2(BOUNCE_LEN) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  logic [1:0]    r_state;
  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_sweep;
  logic [1:0]    r_speed;
  logic [7:0]    r_initstate;
  logic          r_load;
  logic          r_step;
  logic          r_dir;
  logic          r_busy;
  logic [1:0]    r_patIdx;

  logic [1:0]    w_nextState;
  logic [1:0]    w_nextIdx;
  logic [PW:0]   w_period;
  logic          w_wrap;
  logic          w_enterLoad;

  function automatic logic [7:0] seedOf(input logic [1:0] idx);
    case (idx)
      2'd0:    seedOf = 8'b00000011;
      2'd1:    seedOf = 8'b00000001;
      2'd2:    seedOf = 8'b10000001;
      default: seedOf = 8'b00001111;
    endcase
  endfunction

  assign w_period    = (PW+1)'(DIV_BASE) << r_speed;
  assign w_wrap      = ({1'b0, r_presc} == (w_period - 1'b1));
  assign w_enterLoad = (w_nextState == ST_LOAD);

  // Request decode: stop beats next_pat beats start, among the requests a state honours.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_patIdx;
    case (r_state)
      ST_IDLE: begin
        if (bus.next_pat)   w_nextIdx = r_patIdx + 2'd1;
        else if (bus.start) w_nextState = ST_LOAD;
      end
      ST_LOAD: w_nextState = ST_RUN;
      ST_RUN: begin
        if (bus.stop) begin
          w_nextState = ST_PAUSE;
        end else if (bus.next_pat) begin
          w_nextIdx   = r_patIdx + 2'd1;
          w_nextState = ST_LOAD;
        end
      end
      ST_PAUSE: begin
        if (bus.next_pat) begin
          w_nextIdx   = r_patIdx + 2'd1;
          w_nextState = ST_LOAD;
        end else if (bus.start) begin
          w_nextState = ST_RUN;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // The prescaler advances to 1 while leaving LOAD so the first step lands P cycles after load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_sweep     <= '0;
      r_speed     <= 2'd0;
      r_initstate <= 8'h00;
      r_load      <= 1'b0;
      r_step      <= 1'b0;
      r_dir       <= 1'b0;
      r_busy      <= 1'b0;
      r_patIdx    <= 2'd0;
    end else begin
      r_state  <= w_nextState;
      r_patIdx <= w_nextIdx;
      r_busy   <= (w_nextState == ST_RUN);
      r_load   <= w_enterLoad;
      r_step   <= 1'b0;
      if (w_enterLoad) begin
        r_initstate <= seedOf(w_nextIdx);
        r_presc     <= '0;
        r_sweep     <= '0;
        r_dir       <= 1'b0;
      end else begin
        if (r_state == ST_LOAD) begin
          r_presc <= PW'(1);
          r_speed <= bus.speed_sel;
        end else if (r_state == ST_RUN && w_nextState == ST_RUN) begin
          if (w_wrap) begin
            r_presc <= '0;
            r_step  <= 1'b1;
            r_speed <= bus.speed_sel;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        // Sweep accounting happens after the step is presented, so dir flips for the next one.
        if (!bus.bounce) begin
          r_sweep <= '0;
        end else if (r_step) begin
          if (r_sweep == SW'(BOUNCE_LEN - 1)) begin
            r_sweep <= '0;
            r_dir   <= ~r_dir;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
      end
    end
  end

  assign bus.initstate = r_initstate;
  assign bus.load      = r_load;
  assign bus.step      = r_step;
  assign bus.dir       = r_dir;
  assign bus.busy      = r_busy;
  assign bus.pat_idx   = r_patIdx;

endmodule
